dram_burst_master: RTL and testbench
====================================

# dram_burst_master

Request-side engine for the single-port DRAM model, sitting between accelerator logic and the memory port. It accepts one burst command at a time over a valid/ready handshake and drives the memory's `wr`/`addr`/`din` pins beat by beat. Write data arrives on a valid/ready stream. Read data returns through a 2-entry output FIFO with flow control, which hides the memory's 1-cycle registered read latency and lets backpressure stall issue without losing beats.

## Interface
- `DATA`, 32, data word width; must match the memory.
- `ADDR`, 28, word address width; must match the memory.
- `LEN`, 8, burst length field width; a burst is `req_len + 1` beats.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  burst command valid.
- `req_ready`  out  1  command accepted when both `req_valid` and `req_ready` are high.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  ADDR  first word address.
- `req_len`  in  LEN  number of beats minus 1.
- `wdata_valid`  in  1  write beat valid.
- `wdata_ready`  out  1  write beat accepted.
- `wdata`  in  DATA  write beat payload.
- `rdata_valid`  out  1  read beat valid (FIFO head).
- `rdata_ready`  in  1  consumer accepts the read beat.
- `rdata`  out  DATA  read beat payload.
- `rdata_last`  out  1  marks the final beat of a read burst.
- `done`  out  1  one-cycle pulse when a burst completes.
- `mem_wr`  out  1  to memory `wr`.
- `mem_addr`  out  ADDR  to memory `addr`.
- `mem_din`  out  DATA  to memory `din`.
- `mem_dout`  in  DATA  from memory `dout`; valid in the cycle after a read issue.

## Operation
- **Registers:** `cur_addr` (ADDR), `beats_left` (LEN), `inflight` (1 bit), `fifo_count` (0..2), `last_issued` flag.
- **FSM states:** IDLE, WRITE, READ, DRAIN.
- **IDLE**
  - `req_ready = 1`.
  - On handshake: latch `cur_addr = req_addr` and `beats_left = req_len`.
  - Go to WRITE if `req_write`, else READ.
- **WRITE**
  - `wdata_ready = 1`.
  - `mem_wr = wdata_valid`, `mem_addr = cur_addr`, `mem_din = wdata`, all combinational.
  - On each accepted beat, increment `cur_addr` modulo 2^ADDR.
  - If `beats_left == 0` on that beat: go to IDLE and pulse `done` next cycle. Otherwise decrement `beats_left`.
  - Cycles with `wdata_valid = 0` leave `mem_wr = 0` and hold the counters.
- **READ**
  - Issue condition: `fifo_count + inflight < 2 + (rdata_valid && rdata_ready)`.
  - On issue: `mem_wr = 0`, `mem_addr = cur_addr`; set `inflight` for the next cycle; advance `cur_addr`/`beats_left` as in WRITE.
  - If the issued beat is the last, set `last_issued` and go to DRAIN.
- **Capture:** when `inflight` is set, push `mem_dout` into the FIFO at the end of that cycle. The push is tagged last if that beat was the final issue.
- **DRAIN:** no issue. When the last-tagged beat pops (`rdata_valid && rdata_ready && rdata_last`), go to IDLE and pulse `done` next cycle.
- **Outside READ/DRAIN:** `mem_addr` holds `cur_addr` and `mem_wr = 0` in all non-write cycles.
- **FIFO:** 2-entry, in order. A push and a pop in the same cycle are both legal; the count stays unchanged. The FIFO never overflows, guaranteed by the issue condition.
- **Arithmetic:** addresses wrap from 2^ADDR−1 to 0. `req_len = 0` means one beat; maximum burst is 2^LEN beats.
- Commands never overlap. `req_ready` is low outside IDLE.

## Timing
- **Reset values:** state IDLE; `req_ready = 1`; `wdata_ready`, `rdata_valid`, `rdata_last`, `done`, `mem_wr` = 0; `mem_addr`, `mem_din`, `rdata` = 0; FIFO empty; `inflight = 0`.
- **Write:** command accepted in cycle T → `wdata_ready` high from T+1. Beat i is written in the cycle it is accepted. `done` is high in the cycle after the last beat, and that same cycle is in IDLE with `req_ready = 1`.
- **Read, no backpressure:** command accepted in T → first issue T+1 → data on `mem_dout` at T+2 → `rdata_valid` at T+3. Then one beat per cycle. `done` one cycle after the last pop.
- **Read, backpressure:** at most 2 beats are buffered or in flight. `rdata`/`rdata_last` stay stable while `rdata_valid && !rdata_ready`.
- **Reset mid-burst:** `rst_n` low immediately forces `mem_wr = 0` and clears the FIFO, counters and state. The burst is abandoned and there is no `done`.

## Test plan
- Write burst, `req_addr = 0x10`, `req_len = 3`, data A0..A3 back-to-back → `mem_wr` high 4 consecutive cycles at addresses 0x10..0x13 with A0..A3; `done` one cycle later.
- Read back 0x10 `len 3`, `rdata_ready = 1` → `rdata` A0..A3 on T+3..T+6; `rdata_last` only on A3; `done` at T+7.
- Same read with `rdata_ready` low for 5 cycles after the first valid → no more than 2 issues beyond popped beats; A0..A3 delivered in order, none lost or duplicated.
- Write at 0xFFFFFFF, `len 1` → beats land at 0xFFFFFFF then 0x0000000; reading back returns both values.
- Write burst with `wdata_valid` pattern 1,0,0,1,1,0,1 (`len 3`) → `mem_wr` asserted only on the 4 valid cycles; addresses are contiguous.
- Assert `rst_n` low during a read after 2 beats → `rdata_valid`/`mem_wr`/`done` = 0 immediately. After release, `req_ready = 1` and a fresh `len 0` read returns the correct word.

Source files
------------

// File: rtl/dram_burst_if.sv
// Bus bundle between accelerator logic, the burst master and the single-port DRAM pins.
// The master modport belongs to the burst engine; slave is the accelerator/memory side.
interface dram_burst_if #(
   parameter int DATA = 32,
   parameter int ADDR = 28,
   parameter int LEN  = 8
);
   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [ADDR-1:0] req_addr;
   logic [LEN-1:0]  req_len;
   logic            wdata_valid;
   logic            wdata_ready;
   logic [DATA-1:0] wdata;
   logic            rdata_valid;
   logic            rdata_ready;
   logic [DATA-1:0] rdata;
   logic            rdata_last;
   logic            done;
   logic            mem_wr;
   logic [ADDR-1:0] mem_addr;
   logic [DATA-1:0] mem_din;
   logic [DATA-1:0] mem_dout;

   modport master (
      input  req_valid, req_write, req_addr, req_len,
      input  wdata_valid, wdata, rdata_ready, mem_dout,
      output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
      output mem_wr, mem_addr, mem_din
   );

   modport slave (
      output req_valid, req_write, req_addr, req_len,
      output wdata_valid, wdata, rdata_ready, mem_dout,
      input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
      input  mem_wr, mem_addr, mem_din
   );
endinterface

// File: rtl/dram_burst_master.sv
// Burst request engine for a single-port DRAM with 1-cycle registered read latency.
// Reads return through a 2-entry FIFO so consumer backpressure throttles issue without loss.
module dram_burst_master #(
   parameter int DATA = 32,
   parameter int ADDR = 28,
   parameter int LEN  = 8
) (
   input logic          clk,
   input logic          rst_n,
   dram_burst_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

   state_t          state_q, state_d;
   logic [ADDR-1:0] cur_addr_q, cur_addr_d;
   logic [LEN-1:0]  beats_left_q, beats_left_d;
   logic            inflight_q, inflight_d;
   logic            last_issued_q, last_issued_d;
   logic            done_q, done_d;
   logic [1:0]      fifo_count_q, fifo_count_d;
   logic            fifo_wr_ptr_q, fifo_rd_ptr_q;
   logic [DATA-1:0] fifo_data_q [2];
   logic [1:0]      fifo_last_q;

   logic            push, pop, head_valid, head_last, issue_ok, beat_adv;
   logic            req_ready, wdata_ready, mem_wr;
   logic [DATA-1:0] mem_din;

   assign head_valid = (fifo_count_q != 2'd0);
   assign head_last  = head_valid & fifo_last_q[fifo_rd_ptr_q];
   assign pop        = head_valid & bus.rdata_ready;
   assign push       = inflight_q;

   // At most two beats buffered or in flight; a same-cycle pop frees one slot.
   assign issue_ok = ({1'b0, fifo_count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

   always_comb begin
      state_d       = state_q;
      cur_addr_d    = cur_addr_q;
      beats_left_d  = beats_left_q;
      inflight_d    = 1'b0;
      last_issued_d = 1'b0;
      done_d        = 1'b0;
      req_ready     = 1'b0;
      wdata_ready   = 1'b0;
      mem_wr        = 1'b0;
      mem_din       = '0;
      beat_adv      = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               cur_addr_d   = bus.req_addr;
               beats_left_d = bus.req_len;
               state_d      = bus.req_write ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            wdata_ready = 1'b1;
            mem_wr      = bus.wdata_valid;
            mem_din     = bus.wdata;
            if (bus.wdata_valid) begin
               beat_adv = 1'b1;
               if (beats_left_q == '0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         S_READ: begin
            if (issue_ok) begin
               beat_adv   = 1'b1;
               inflight_d = 1'b1;
               if (beats_left_q == '0) begin
                  last_issued_d = 1'b1;
                  state_d       = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && head_last) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (beat_adv) begin
         cur_addr_d = cur_addr_q + ADDR'(1);
         if (beats_left_q != '0) beats_left_d = beats_left_q - LEN'(1);
      end
   end

   always_comb begin
      fifo_count_d = fifo_count_q;
      case ({push, pop})
         2'b10:   fifo_count_d = fifo_count_q + 2'd1;
         2'b01:   fifo_count_d = fifo_count_q - 2'd1;
         default: fifo_count_d = fifo_count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cur_addr_q    <= '0;
         beats_left_q  <= '0;
         inflight_q    <= 1'b0;
         last_issued_q <= 1'b0;
         done_q        <= 1'b0;
         fifo_count_q  <= 2'd0;
         fifo_wr_ptr_q <= 1'b0;
         fifo_rd_ptr_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_addr_q    <= cur_addr_d;
         beats_left_q  <= beats_left_d;
         inflight_q    <= inflight_d;
         last_issued_q <= last_issued_d;
         done_q        <= done_d;
         fifo_count_q  <= fifo_count_d;
         if (push) fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
         if (pop)  fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      end
   end

   // Captured read data is gated by the count, so storage needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[fifo_wr_ptr_q] <= bus.mem_dout;
         fifo_last_q[fifo_wr_ptr_q] <= last_issued_q;
      end
   end

   assign bus.req_ready   = req_ready;
   assign bus.wdata_ready = wdata_ready;
   assign bus.mem_wr      = mem_wr;
   assign bus.mem_din     = mem_din;
   assign bus.mem_addr    = cur_addr_q;
   assign bus.rdata_valid = head_valid;
   assign bus.rdata       = head_valid ? fifo_data_q[fifo_rd_ptr_q] : '0;
   assign bus.rdata_last  = head_last;
   assign bus.done        = done_q;
endmodule

// File: tb/tb_dram_burst_master.sv
// Bench for dram_burst_master: DRAM model, burst command table and write/read scoreboards.
// Hand-written sequences cover reset values and reset in the middle of a read burst.
module tb_dram_burst_master;
   localparam int DATA = 32;
   localparam int ADDR = 28;
   localparam int LEN  = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dram_burst_if #(.DATA(DATA), .ADDR(ADDR), .LEN(LEN)) bus ();

   dram_burst_master #(.DATA(DATA), .ADDR(ADDR), .LEN(LEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Single-port DRAM with registered read.
   logic [DATA-1:0] dram    [logic [ADDR-1:0]];
   logic [DATA-1:0] ref_mem [logic [ADDR-1:0]];
   always @(posedge clk) begin
      bus.mem_dout <= dram.exists(bus.mem_addr) ? dram[bus.mem_addr] : '0;
      if (bus.mem_wr === 1'b1) dram[bus.mem_addr] = bus.mem_din;
   end

   typedef struct packed { logic [ADDR-1:0] a; logic [DATA-1:0] d; } wexp_t;
   typedef struct packed { logic [DATA-1:0] d; logic l; } rexp_t;
   wexp_t wq[$];
   rexp_t rq[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors sample just after the falling edge.
   always begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && bus.mem_wr === 1'b1) begin
         if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected: mem_wr at addr %0h data %0h, expected none", bus.mem_addr, bus.mem_din);
         end else begin
            wexp_t e;
            e = wq.pop_front();
            check("wr_addr", 64'(bus.mem_addr), 64'(e.a));
            check("wr_data", 64'(bus.mem_din), 64'(e.d));
         end
      end
      if (rst_n === 1'b1 && bus.rdata_valid === 1'b1 && bus.rdata_ready === 1'b1) begin
         if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: popped %0h, expected none", bus.rdata);
         end else begin
            rexp_t r;
            r = rq.pop_front();
            check("rd_data", 64'(bus.rdata), 64'(r.d));
            check("rd_last", 64'(bus.rdata_last), 64'(r.l));
         end
      end
   end

   task automatic send_req(input logic wr, input logic [ADDR-1:0] addr, input int len, output bit ok);
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_len   = len[LEN-1:0];
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.req_ready === 1'b1) ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL req_accept: req_ready got 0 expected 1 within 50 cycles");
         bus.req_valid = 1'b0;
      end
   endtask

   task automatic do_write(input logic [ADDR-1:0] addr, input int len, input logic [DATA-1:0] seed,
                           input logic [15:0] pat, input int pat_n, input int exp_done, input string tag);
      int cyc, beat;
      bit ok;
      logic [ADDR-1:0] a;
      send_req(1'b1, addr, len, ok);
      if (!ok) return;
      beat = 0;
      cyc  = 0;
      while (beat <= len && cyc < 200) begin
         cyc++;
         @(posedge clk); #1;
         bus.req_valid   = 1'b0;
         bus.wdata_valid = (cyc - 1 < pat_n) ? pat[cyc-1] : 1'b1;
         bus.wdata       = seed + DATA'(beat);
         @(negedge clk);
         if (bus.wdata_valid && bus.wdata_ready === 1'b1) begin
            a = addr + ADDR'(beat);
            wq.push_back('{a: a, d: bus.wdata});
            ref_mem[a] = bus.wdata;
            beat++;
         end
      end
      @(posedge clk); #1;
      bus.wdata_valid = 1'b0;
      cyc++;
      @(negedge clk);
      check($sformatf("%s_beats", tag), 64'(beat), 64'(len + 1));
      check($sformatf("%s_done", tag), 64'(bus.done), 64'(1));
      check($sformatf("%s_req_ready", tag), 64'(bus.req_ready), 64'(1));
      if (exp_done >= 0) check($sformatf("%s_done_cycle", tag), 64'(cyc), 64'(exp_done));
      #2;
      check($sformatf("%s_wq_empty", tag), 64'(wq.size()), 64'(0));
   endtask

   task automatic do_read(input logic [ADDR-1:0] addr, input int len, input int stall,
                          input int exp_done, input int abort_pops, input string tag);
      int cyc, pops, first_v, last_pop, done_c;
      bit ok, hold_bad, out_bad, prev_stall;
      logic [DATA-1:0] prev_d, exp_d;
      logic            prev_l;
      logic [ADDR-1:0] a, adv;
      for (int i = 0; i <= len; i++) begin
         a     = addr + ADDR'(i);
         exp_d = ref_mem.exists(a) ? ref_mem[a] : '0;
         rq.push_back('{d: exp_d, l: (i == len)});
      end
      send_req(1'b0, addr, len, ok);
      if (!ok) return;
      cyc = 0; pops = 0; first_v = -1; last_pop = -1; done_c = -1;
      hold_bad = 1'b0; out_bad = 1'b0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
      while (done_c < 0 && cyc < 300) begin
         cyc++;
         @(posedge clk); #1;
         bus.req_valid   = 1'b0;
         bus.rdata_ready = (stall == 0) || (first_v >= 0 && cyc >= first_v + stall);
         @(negedge clk);
         if (prev_stall && (bus.rdata !== prev_d || bus.rdata_last !== prev_l)) hold_bad = 1'b1;
         prev_stall = bus.rdata_valid && !bus.rdata_ready;
         prev_d     = bus.rdata;
         prev_l     = bus.rdata_last;
         adv        = bus.mem_addr - addr;
         if (int'(adv) - pops > 2) out_bad = 1'b1;
         if (bus.rdata_valid === 1'b1 && first_v < 0) first_v = cyc;
         if (bus.rdata_valid === 1'b1 && bus.rdata_ready) begin
            pops++;
            if (bus.rdata_last === 1'b1) last_pop = cyc;
         end
         if (bus.done === 1'b1) done_c = cyc;
         if (abort_pops >= 0 && pops == abort_pops) break;
      end
      if (abort_pops >= 0) return;
      check($sformatf("%s_pops", tag), 64'(pops), 64'(len + 1));
      check($sformatf("%s_done_gap", tag), 64'(done_c - last_pop), 64'(1));
      check($sformatf("%s_outstanding", tag), 64'(out_bad), 64'(0));
      if (stall > 0) check($sformatf("%s_hold_stable", tag), 64'(hold_bad), 64'(0));
      if (exp_done >= 0) begin
         check($sformatf("%s_first_valid", tag), 64'(first_v), 64'(3));
         check($sformatf("%s_done_cycle", tag), 64'(done_c), 64'(exp_done));
      end
      check($sformatf("%s_rq_empty", tag), 64'(rq.size()), 64'(0));
   endtask

   typedef struct {
      bit              wr;
      logic [ADDR-1:0] addr;
      int              len;
      int              stall;
      logic [15:0]     pat;
      int              pat_n;
      logic [DATA-1:0] seed;
      int              exp_done;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time exceeded");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{1'b1, 28'h0000010,  3, 0, 16'h0000, 0, 32'h000000A0, 5};
      vecs[1]  = '{1'b0, 28'h0000010,  3, 0, 16'h0000, 0, 32'h00000000, 7};
      vecs[2]  = '{1'b0, 28'h0000010,  3, 5, 16'h0000, 0, 32'h00000000, -1};
      vecs[3]  = '{1'b1, 28'hFFFFFFF,  1, 0, 16'h0000, 0, 32'h5EED0000, 3};
      vecs[4]  = '{1'b0, 28'hFFFFFFF,  1, 0, 16'h0000, 0, 32'h00000000, 5};
      vecs[5]  = '{1'b1, 28'h0000200,  3, 0, 16'h0059, 7, 32'hC0DE0000, 8};
      vecs[6]  = '{1'b0, 28'h0000200,  3, 0, 16'h0000, 0, 32'h00000000, 7};
      vecs[7]  = '{1'b1, 28'h0000300,  0, 0, 16'h0000, 0, 32'h12345678, 2};
      vecs[8]  = '{1'b0, 28'h0000300,  0, 0, 16'h0000, 0, 32'h00000000, 4};
      vecs[9]  = '{1'b1, 28'h0000400, 20, 0, 16'h0000, 0, 32'h40000000, 22};
      vecs[10] = '{1'b0, 28'h0000400, 20, 3, 16'h0000, 0, 32'h00000000, -1};

      rst_n           = 1'b0;
      bus.req_valid   = 1'b0;
      bus.req_write   = 1'b0;
      bus.req_addr    = '0;
      bus.req_len     = '0;
      bus.wdata_valid = 1'b0;
      bus.wdata       = '0;
      bus.rdata_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_req_ready",   64'(bus.req_ready),   64'(1));
      check("rst_wdata_ready", 64'(bus.wdata_ready), 64'(0));
      check("rst_rdata_valid", 64'(bus.rdata_valid), 64'(0));
      check("rst_rdata_last",  64'(bus.rdata_last),  64'(0));
      check("rst_done",        64'(bus.done),        64'(0));
      check("rst_mem_wr",      64'(bus.mem_wr),      64'(0));
      check("rst_mem_addr",    64'(bus.mem_addr),    64'(0));
      check("rst_mem_din",     64'(bus.mem_din),     64'(0));
      check("rst_rdata",       64'(bus.rdata),       64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int v = 0; v < 11; v++) begin
         if (vecs[v].wr)
            do_write(vecs[v].addr, vecs[v].len, vecs[v].seed, vecs[v].pat, vecs[v].pat_n,
                     vecs[v].exp_done, $sformatf("v%0d_wr", v));
         else
            do_read(vecs[v].addr, vecs[v].len, vecs[v].stall, vecs[v].exp_done, -1,
                    $sformatf("v%0d_rd", v));
      end

      // Reset in the middle of a read burst after two beats have been popped.
      do_read(28'h0000010, 3, 0, -1, 2, "abort_rd");
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_rdata_valid", 64'(bus.rdata_valid), 64'(0));
      check("abort_mem_wr",      64'(bus.mem_wr),      64'(0));
      check("abort_done",        64'(bus.done),        64'(0));
      rq.delete();
      wq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.rdata_ready = 1'b0;
      @(negedge clk);
      check("abort_req_ready",  64'(bus.req_ready),   64'(1));
      check("abort_no_valid",   64'(bus.rdata_valid), 64'(0));
      check("abort_no_done",    64'(bus.done),        64'(0));
      do_read(28'h0000011, 0, 0, 4, -1, "post_rst_rd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
